// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant
// encodings, memory access modes and the latched command/load-context payloads.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_F = 2'b01,
        BUSY_D = 2'b10,
        RESP   = 2'b11
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_e;

    // Memory command held stable on the bus for the whole busy phase
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // Everything needed to extract load data once the memory answers
    typedef struct packed {
        mem_mode_e  mode;
        logic [1:0] lane;
        logic       uns;
    } ld_ctx_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables, store-data replication,
// load lane selection with sign/zero extension, and the misaligned flag.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]      mode_i,
    input  logic [1:0]      lane_i,
    input  logic            is_load_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [BE_W-1:0] be_c_o,
    output logic [XLEN-1:0] wdata_c_o,
    output logic [XLEN-1:0] rdata_c_o,
    output logic            misaligned_c_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Loads and word stores keep all lanes enabled and data unreplicated
    always_comb begin
        be_c_o         = '1;
        wdata_c_o      = wdata_i;
        rdata_c_o      = rdata_i;
        misaligned_c_o = 1'b0;
        case (mode_i)
            MEM_BYTE: begin
                if (!is_load_i) begin
                    be_c_o    = BE_W'(1) << lane_i;
                    wdata_c_o = {(XLEN/8){wdata_i[7:0]}};
                end
                rdata_c_o = {{(XLEN-8){byte_sel[7] & ~unsigned_i}}, byte_sel};
            end
            MEM_HALF: begin
                misaligned_c_o = lane_i[0];
                if (!is_load_i) begin
                    be_c_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                    wdata_c_o = {(XLEN/16){wdata_i[15:0]}};
                end
                rdata_c_o = {{(XLEN-16){half_sel[15] & ~unsigned_i}}, half_sel};
            end
            default: begin
                misaligned_c_o = |lane_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Optional transfer timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [1:0]      d_mode,
    input  logic            d_unsigned,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_done,
    output logic            d_misaligned,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            bus_error,
    output logic            stall
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e      state_q, state_d;
    grant_e          last_q, last_d;
    ld_ctx_t         ctx_q, ctx_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic            mem_req_q, mem_req_d;
    logic            if_done_q, if_done_d;
    logic            d_done_q, d_done_d;
    logic            d_mis_q, d_mis_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    logic [1:0]      al_mode;
    logic [1:0]      al_lane;
    logic            al_load;
    logic            al_uns;
    logic [BE_W-1:0] al_be;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            al_mis;
    logic            d_wins;
    logic            unused_if_addr_lo;

    assign unused_if_addr_lo = ^if_addr[1:0];

    // Live data-port request while arbitrating, latched context while busy
    always_comb begin
        if (state_q == IDLE) begin
            al_mode = d_mode;
            al_lane = d_addr[1:0];
            al_load = ~d_we;
            al_uns  = d_unsigned;
        end else begin
            al_mode = ctx_q.mode;
            al_lane = ctx_q.lane;
            al_load = 1'b1;
            al_uns  = ctx_q.uns;
        end
    end

    mem_lane_align u_align (
        .mode_i         (al_mode),
        .lane_i         (al_lane),
        .is_load_i      (al_load),
        .unsigned_i     (al_uns),
        .wdata_i        (d_wdata),
        .rdata_i        (mem_rdata),
        .be_c_o         (al_be),
        .wdata_c_o      (al_wdata),
        .rdata_c_o      (al_rdata),
        .misaligned_c_o (al_mis)
    );

    // Data wins contention unless it had the previous grant, so ports alternate
    assign d_wins = d_req & ~((last_q == DATA) & if_req);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        ctx_d      = ctx_q;
        cmd_d      = cmd_q;
        mem_req_d  = 1'b0;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        d_mis_d    = 1'b0;
        if_rdata_d = '0;
        d_rdata_d  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cmd_d = '0;
                if (d_wins) begin
                    last_d     = DATA;
                    ctx_d.mode = mem_mode_e'(d_mode);
                    ctx_d.lane = d_addr[1:0];
                    ctx_d.uns  = d_unsigned;
                    if (al_mis) begin
                        state_d  = RESP;
                        d_done_d = 1'b1;
                        d_mis_d  = 1'b1;
                    end else begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        cmd_d.we    = d_we;
                        cmd_d.addr  = {d_addr[XLEN-1:2], 2'b00};
                        cmd_d.be    = al_be;
                        cmd_d.wdata = d_we ? al_wdata : '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end
                end else if (if_req) begin
                    last_d      = FETCH;
                    state_d     = BUSY_F;
                    mem_req_d   = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = {if_addr[XLEN-1:2], 2'b00};
                    cmd_d.be    = '1;
                    cmd_d.wdata = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY_F, BUSY_D: begin
                if (mem_ack) begin
                    state_d = RESP;
                    cmd_d   = '0;
                    if (state_q == BUSY_F) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = al_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    cmd_d     = '0;
                    bus_err_d = 1'b1;
                    if (state_q == BUSY_F) begin
                        if_done_d = 1'b1;
                    end else begin
                        d_done_d = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
`else
                else begin
                    mem_req_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= FETCH;
            ctx_q      <= '0;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            d_mis_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            ctx_q      <= ctx_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            d_mis_q    <= d_mis_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_done      = if_done_q;
    assign d_rdata      = d_rdata_q;
    assign d_done       = d_done_q;
    assign d_misaligned = d_mis_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = cmd_q.we;
    assign mem_addr     = cmd_q.addr;
    assign mem_be       = cmd_q.be;
    assign mem_wdata    = cmd_q.wdata;
    assign stall        = (if_req & ~if_done_q) | (d_req & ~d_done_q);

`ifdef MEM_ARB_TIMEOUT_EN
    assign bus_error = bus_err_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_mode = 2'b10;
    logic        d_unsigned = 1'b0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_error;
    logic        stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mode(d_mode), .d_unsigned(d_unsigned), .d_rdata(d_rdata),
        .d_done(d_done), .d_misaligned(d_misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_error(bus_error), .stall(stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    bit          ack_en = 1'b1;
    bit          rand_resp = 1'b0;
    int          ack_delay = 1;
    logic [31:0] fixed_rdata = '0;
    int          busy_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (ack_en && busy_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rand_resp ? $urandom : fixed_rdata;
                    busy_cnt  = 0;
                    if (rand_resp) ack_delay = $urandom_range(0, 3);
                end else begin
                    mem_ack = 1'b0;
                    busy_cnt++;
                end
            end else begin
                busy_cnt  = 0;
                mem_ack   = rand_resp && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          model_on = 1'b0;
    int          m_phase = 0;     // 0 waiting for grant, 1 memory cycle open, 2 completion cycle
    bit          m_port = 1'b0;   // 1 = data
    bit          m_last = 1'b0;   // 1 = data had the last grant
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0;
    int unsigned m_size = 4;
    int unsigned m_lane = 0;
    bit          m_uns = 1'b0;
    bit          m_if_done = 1'b0, m_d_done = 1'b0, m_mis = 1'b0, m_berr = 1'b0;
    bit          m_chk_drd = 1'b0;
    logic [31:0] m_if_rdata = '0, m_d_rdata = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    int          m_wait = 0;
`endif

    function automatic logic [31:0] load_value(input logic [31:0] word, input int unsigned size,
                                               input int unsigned lane, input bit uns);
        logic [31:0] mask, v;
        if (size == 4) return word;
        mask = (32'h1 << (8 * size)) - 32'h1;
        v = (word >> (8 * lane)) & mask;
        if (!uns && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    initial begin
        logic exp_stall;
        bit   take_d;
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("mem_req", mem_req, (m_phase == 1));
                if (m_phase == 1) begin
                    chk("mem_addr", mem_addr, m_addr);
                    chk("mem_we", mem_we, m_we);
                    chk("mem_be", mem_be, m_be);
                    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                end
                chk("if_done", if_done, m_if_done);
                chk("d_done", d_done, m_d_done);
                chk("d_misaligned", d_misaligned, m_mis);
                chk("bus_error", bus_error, m_berr);
                if (m_if_done) chk("if_rdata", if_rdata, m_if_rdata);
                if (m_chk_drd) chk("d_rdata", d_rdata, m_d_rdata);
                exp_stall = (if_req & ~m_if_done) | (d_req & ~m_d_done);
                chk("stall", stall, exp_stall);
            end
            // advance to next cycle's expectation
            m_if_done = 0; m_d_done = 0; m_mis = 0; m_berr = 0; m_chk_drd = 0;
            if (rst) begin
                m_phase = 0;
                m_last  = 0;
            end else begin
                case (m_phase)
                    2: m_phase = 0;
                    1: begin
                        if (mem_ack) begin
                            m_phase = 2;
                            if (m_port) begin
                                m_d_done  = 1;
                                m_chk_drd = !m_we;
                                m_d_rdata = load_value(mem_rdata, m_size, m_lane, m_uns);
                            end else begin
                                m_if_done  = 1;
                                m_if_rdata = mem_rdata;
                            end
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        else if (m_wait == TO - 1) begin
                            m_phase = 2;
                            m_berr  = 1;
                            if (m_port) begin
                                m_d_done = 1; m_chk_drd = 1; m_d_rdata = 0;
                            end else begin
                                m_if_done = 1; m_if_rdata = 0;
                            end
                        end else begin
                            m_wait++;
                        end
`endif
                    end
                    default: begin
                        take_d = d_req && !(m_last && if_req);
                        if (take_d) begin
                            m_last = 1;
                            m_port = 1;
                            m_size = 1 << d_mode;
                            m_lane = d_addr & 3;
                            m_uns  = d_unsigned;
                            m_we   = d_we;
                            if ((d_addr & (m_size - 1)) != 0) begin
                                m_phase = 2; m_d_done = 1; m_mis = 1; m_chk_drd = 1; m_d_rdata = 0;
                            end else begin
                                m_phase = 1;
                                m_addr  = d_addr & ~32'h3;
                                m_be    = d_we ? 4'(((1 << m_size) - 1) << m_lane) : 4'hF;
                                if (m_size == 1)      m_wdata = (d_wdata & 32'hFF) * 32'h01010101;
                                else if (m_size == 2) m_wdata = (d_wdata & 32'hFFFF) * 32'h00010001;
                                else                  m_wdata = d_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                                m_wait = 0;
`endif
                            end
                        end else if (if_req) begin
                            m_last  = 0;
                            m_port  = 0;
                            m_phase = 1;
                            m_we    = 0;
                            m_addr  = if_addr & ~32'h3;
                            m_be    = 4'hF;
`ifdef MEM_ARB_TIMEOUT_EN
                            m_wait = 0;
`endif
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_d_done(input string nm, output int n);
        n = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (d_done) begin
                n = c;
                break;
            end
        end
        if (n < 0) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting for d_done", nm);
        end
    endtask

    task automatic run_random(input int ncyc);
        bit fseen, dseen;
        rand_resp = 1'b1; ack_en = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            fseen = if_done; dseen = d_done;
            cyc();
            if (!if_req || fseen) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!d_req || dseen) begin
                d_req      = ($urandom_range(0, 2) != 0);
                d_we       = $urandom_range(0, 1);
                d_mode     = 2'($urandom_range(0, 2));
                d_unsigned = $urandom_range(0, 1);
                d_wdata    = $urandom;
                d_addr     = $urandom;
                if ($urandom_range(0, 1) == 1) d_addr[1:0] = 2'b00;
            end
        end
        for (int i = 0; i < 64 && (if_req || d_req); i++) begin
            @(negedge clk);
            fseen = if_done; dseen = d_done;
            cyc();
            if (fseen) if_req = 1'b0;
            if (dseen) d_req = 1'b0;
        end
        chk("random_drain", {30'd0, if_req, d_req}, 32'd0);
        rand_resp = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios then random ----------------
    initial begin
        int found;
        int g[4];
        int ng;
        logic prev_req;

        do_reset();
        model_on = 1'b1;
        @(negedge clk);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_be", mem_be, 0);
        chk("reset_if_done", if_done, 0);
        chk("reset_d_done", d_done, 0);
        chk("reset_bus_error", bus_error, 0);

        // single fetch, ack one cycle after mem_req rises
        do_reset();
        rand_resp = 1'b0; ack_en = 1'b1; ack_delay = 1; fixed_rdata = 32'h00500093;
        if_req = 1'b1; if_addr = 32'h100;
        found = -1;
        for (int c = 0; c < 10 && found < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("fetch_mem_addr", mem_addr, 32'h100);
                chk("fetch_stall_wait", stall, 1);
            end
            if (if_done) begin
                found = c;
                chk("fetch_rdata", if_rdata, 32'h00500093);
            end
        end
        chk("fetch_done_cycle", found, 3);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_stall_after", stall, 0);

        // continuous contention alternates D,F,D,F
        do_reset();
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_mode = MEM_WORD; d_unsigned = 1'b0;
        g = '{-1, -1, -1, -1};
        ng = 0; prev_req = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                g[ng] = (mem_addr == 32'h2000) ? 1 : 0;
                ng++;
            end
            prev_req = mem_req;
        end
        chk("grant0_data", g[0], 1);
        chk("grant1_fetch", g[1], 0);
        chk("grant2_data", g[2], 1);
        chk("grant3_fetch", g[3], 0);
        cyc();
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) cyc();

        // byte store to 0x203
        do_reset();
        ack_delay = 1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h203; d_wdata = 32'h000000AB; d_mode = MEM_BYTE;
        @(negedge clk);
        @(negedge clk);
        chk("stb_mem_req", mem_req, 1);
        chk("stb_mem_be", mem_be, 32'h8);
        chk("stb_mem_wdata", mem_wdata, 32'hABABABAB);
        chk("stb_mem_we", mem_we, 1);
        chk("stb_mem_addr", mem_addr, 32'h200);
        wait_d_done("stb_done", found);
        cyc();
        d_req = 1'b0;

        // half loads at 0x302, signed then back-to-back unsigned
        do_reset();
        fixed_rdata = 32'h8001_1234;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h302; d_mode = MEM_HALF; d_unsigned = 1'b0;
        wait_d_done("lh_done", found);
        chk("lh_signed", d_rdata, 32'hFFFF8001);
        cyc();
        d_unsigned = 1'b1;
        wait_d_done("lhu_done", found);
        chk("lh_unsigned", d_rdata, 32'h00008001);
        cyc();
        d_req = 1'b0;

        // misaligned word load at 0x105
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h105; d_mode = MEM_WORD;
        @(negedge clk);
        chk("mis_done_c0", d_done, 0);
        @(negedge clk);
        chk("mis_done_c1", d_done, 1);
        chk("mis_flag_c1", d_misaligned, 1);
        chk("mis_rdata_c1", d_rdata, 0);
        chk("mis_mem_req_c1", mem_req, 0);
        cyc();
        d_req = 1'b0;
        @(negedge clk);
        chk("mis_mem_req_c2", mem_req, 0);

        // reset while the data transfer is open
        do_reset();
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_mode = MEM_WORD;
        repeat (3) @(negedge clk);
        chk("rst_busy_mem_req", mem_req, 1);
        cyc();
        rst = 1'b1; d_req = 1'b0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_drop_mem_req", mem_req, 0);
        for (int c = 0; c < 5; c++) begin
            chk("rst_no_done", d_done, 0);
            @(negedge clk);
        end
        ack_en = 1'b1;

        // no acknowledge at all
        do_reset();
        ack_en = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_mode = MEM_WORD;
`ifdef MEM_ARB_TIMEOUT_EN
        found = -1;
        for (int c = 0; c < 40 && found < 0; c++) begin
            @(negedge clk);
            if (d_done) begin
                found = c;
                chk("to_bus_error", bus_error, 1);
                chk("to_rdata", d_rdata, 0);
            end
        end
        chk("to_done_cycle", found, TO + 1);
        cyc();
        d_req = 1'b0;
        ack_en = 1'b1;
`else
        found = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (d_done || !(mem_req || c == 0)) found++;
        end
        chk("noack_still_waiting", found, 0);
        ack_en = 1'b1;
        wait_d_done("noack_release", found);
        cyc();
        d_req = 1'b0;
`endif
        repeat (3) cyc();

        // random traffic
        do_reset();
        run_random(3000);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
